alsu: RTL and testbench

Registered arithmetic-logic-shift unit with two equal-width operands and a double-width result. All inputs are captured in an input register stage and the result is produced in an output register stage. An LED bank flags invalid operation requests by blinking. The block is a standalone datapath leaf driven by a single clock domain.

---
 rtl/alsu.sv | 121 ++++++++++++
 tb/tb_alsu.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/alsu.sv
// Two-stage arithmetic/logic/shift unit; every input is registered, then the result and LED blink are registered.
// Latency 2 clocks; no backpressure, a new operation is accepted every cycle.
module alsu #(
    parameter int BITS           = 3,
    parameter     INPUT_PRIORITY = "A",
    parameter     FULL_ADDER     = "ON"
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BITS-1:0]   A,
    input  logic [BITS-1:0]   B,
    input  logic              cin,
    input  logic              SI,
    input  logic              sh_left,
    input  logic              red_op_A,
    input  logic              red_op_B,
    input  logic              pass_A,
    input  logic              pass_B,
    input  logic [2:0]        opcode,
    output logic [2*BITS-1:0] out,
    output logic [15:0]       leds
);

    localparam int W        = 2 * BITS;
    localparam bit PRIO_A   = (INPUT_PRIORITY == "A");
    localparam bit FULL_ADD = (FULL_ADDER == "ON");

    logic [BITS-1:0] a_d, a_q, b_d, b_q;
    logic            cin_d, cin_q, si_d, si_q, sh_left_d, sh_left_q;
    logic            red_a_d, red_a_q, red_b_d, red_b_q;
    logic            pass_a_d, pass_a_q, pass_b_d, pass_b_q;
    logic [2:0]      opcode_d, opcode_q;
    logic [W-1:0]    out_d, out_q;
    logic [15:0]     leds_d, leds_q;

    logic red_any, use_red_a, invalid;

    always_comb begin
        a_d       = A;
        b_d       = B;
        cin_d     = cin;
        si_d      = SI;
        sh_left_d = sh_left;
        red_a_d   = red_op_A;
        red_b_d   = red_op_B;
        pass_a_d  = pass_A;
        pass_b_d  = pass_B;
        opcode_d  = opcode;
    end

    always_comb begin
        out_d     = '0;
        leds_d    = '0;
        red_any   = red_a_q | red_b_q;
        use_red_a = red_a_q & (~red_b_q | PRIO_A);
        // Reductions are only meaningful for AND/XOR; any other opcode with a reduction flag is a bad request.
        invalid   = (opcode_q[2:1] == 2'b11) || (red_any && (opcode_q[2:1] != 2'b00));

        if (pass_a_q || pass_b_q) begin
            if (pass_a_q && (!pass_b_q || PRIO_A)) begin
                out_d = {{BITS{1'b0}}, a_q};
            end else begin
                out_d = {{BITS{1'b0}}, b_q};
            end
        end else if (invalid) begin
            leds_d = ~leds_q;
        end else begin
            case (opcode_q)
                3'b000: begin
                    if (!red_any)       out_d = {{BITS{1'b0}}, a_q & b_q};
                    else if (use_red_a) out_d = {{(W-1){1'b0}}, &a_q};
                    else                out_d = {{(W-1){1'b0}}, &b_q};
                end
                3'b001: begin
                    if (!red_any)       out_d = {{BITS{1'b0}}, a_q ^ b_q};
                    else if (use_red_a) out_d = {{(W-1){1'b0}}, ^a_q};
                    else                out_d = {{(W-1){1'b0}}, ^b_q};
                end
                3'b010: out_d = W'(a_q) + W'(b_q) + W'(cin_q & FULL_ADD);
                3'b011: out_d = W'(a_q) * W'(b_q);
                3'b100: out_d = sh_left_q ? {out_q[W-2:0], si_q} : {si_q, out_q[W-1:1]};
                3'b101: out_d = sh_left_q ? {out_q[W-2:0], out_q[W-1]} : {out_q[0], out_q[W-1:1]};
                default: out_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            cin_q     <= 1'b0;
            si_q      <= 1'b0;
            sh_left_q <= 1'b0;
            red_a_q   <= 1'b0;
            red_b_q   <= 1'b0;
            pass_a_q  <= 1'b0;
            pass_b_q  <= 1'b0;
            opcode_q  <= '0;
            out_q     <= '0;
            leds_q    <= '0;
        end else begin
            a_q       <= a_d;
            b_q       <= b_d;
            cin_q     <= cin_d;
            si_q      <= si_d;
            sh_left_q <= sh_left_d;
            red_a_q   <= red_a_d;
            red_b_q   <= red_b_d;
            pass_a_q  <= pass_a_d;
            pass_b_q  <= pass_b_d;
            opcode_q  <= opcode_d;
            out_q     <= out_d;
            leds_q    <= leds_d;
        end
    end

    assign out  = out_q;
    assign leds = leds_q;

endmodule

// File: tb/tb_alsu.sv
// Scoreboard bench for alsu (BITS=3, default parameters) with an arithmetic reference model.
module tb_alsu;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] A = '0, B = '0, opcode = '0;
    logic       cin = 1'b0, SI = 1'b0, sh_left = 1'b0;
    logic       red_op_A = 1'b0, red_op_B = 1'b0, pass_A = 1'b0, pass_B = 1'b0;
    logic [5:0] out;
    logic [15:0] leds;

    alsu #(.BITS(3)) dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .cin(cin), .SI(SI), .sh_left(sh_left),
        .red_op_A(red_op_A), .red_op_B(red_op_B), .pass_A(pass_A), .pass_B(pass_B),
        .opcode(opcode), .out(out), .leds(leds)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  o;
        logic [15:0] l;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_out = 0;
    int   m_leds = 0;
    logic drv_vld = 1'b0;
    logic v1, v2;

    // Tracks which cycles carry a scoreboarded operation through the two register stages.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            v1 <= drv_vld;
            v2 <= v1;
        end
    end

    always @(negedge clk) begin
        if (v2 && !rst) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL scoreboard_underflow: out=%0d leds=%h with nothing expected", out, leds);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (out !== e.o || leds !== e.l) begin
                    n_bad++;
                    $display("FAIL %s: got out=%0d leds=%h, expected out=%0d leds=%h",
                             e.tag, out, leds, e.o, e.l);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [5:0] o, input logic [15:0] l);
        n_cmp++;
        if (out !== o || leds !== l) begin
            n_bad++;
            $display("FAIL %s: got out=%0d leds=%h, expected out=%0d leds=%h", tag, out, leds, o, l);
        end
    endtask

    // Called at a negedge; drives one operation, updates the model and returns at the next negedge.
    task automatic issue(input string tag, input int a, input int b, input int ci, input int si,
                         input int shl, input int ra, input int rb, input int pa, input int pb,
                         input int op);
        A = a[2:0]; B = b[2:0]; cin = ci[0]; SI = si[0]; sh_left = shl[0];
        red_op_A = ra[0]; red_op_B = rb[0]; pass_A = pa[0]; pass_B = pb[0]; opcode = op[2:0];
        if (pa != 0 || pb != 0) begin
            m_out  = (pa != 0) ? a : b;
            m_leds = 0;
        end else if (op >= 6 || ((ra != 0 || rb != 0) && op > 1)) begin
            m_out  = 0;
            m_leds = m_leds ^ 32'hFFFF;
        end else begin
            m_leds = 0;
            case (op)
                0: m_out = (ra != 0) ? int'(a == 7) : (rb != 0) ? int'(b == 7) : (a & b);
                1: m_out = (ra != 0) ? ($countones(a) % 2) : (rb != 0) ? ($countones(b) % 2) : (a ^ b);
                2: m_out = a + b + ci;
                3: m_out = a * b;
                4: m_out = (shl != 0) ? (m_out * 2 + si) % 64 : m_out / 2 + si * 32;
                default: m_out = (shl != 0) ? (m_out * 2) % 64 + m_out / 32 : m_out / 2 + (m_out % 2) * 32;
            endcase
        end
        exp_q.push_back('{o: m_out[5:0], l: m_leds[15:0], tag: tag});
        drv_vld = 1'b1;
        @(negedge clk);
    endtask

    task automatic drain();
        drv_vld = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d results still pending, expected 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic do_reset(input string tag);
        drv_vld = 1'b0;
        A = '0; B = '0; cin = 1'b0; SI = 1'b0; sh_left = 1'b0;
        red_op_A = 1'b0; red_op_B = 1'b0; pass_A = 1'b0; pass_B = 1'b0; opcode = '0;
        rst = 1'b1;
        #1;
        check({tag, "_async"}, 6'd0, 16'h0);
        @(negedge clk);
        check({tag, "_hold"}, 6'd0, 16'h0);
        rst = 1'b0;
        m_out  = 0;
        m_leds = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        int a, b, op, ra, rb, pa, pb;
        @(negedge clk);
        do_reset("rst_init");

        //    tag            A  B ci si sl ra rb pa pb op
        issue("add_5_1_1",   5, 1, 1, 0, 0, 0, 0, 0, 0, 2);
        issue("mul_7_7",     7, 7, 0, 0, 0, 0, 0, 0, 0, 3);
        issue("and_6_3",     6, 3, 0, 0, 0, 0, 0, 0, 0, 0);
        issue("xor_6_3",     6, 3, 0, 0, 0, 0, 0, 0, 0, 1);
        issue("redand_a7",   7, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        issue("redxor_both", 3, 1, 0, 0, 0, 1, 1, 0, 0, 1);
        issue("redxor_b6",   0, 6, 0, 0, 0, 0, 1, 0, 0, 1);
        issue("pass_b_inv",  0, 4, 0, 0, 0, 0, 0, 0, 1, 7);
        issue("pass_both",   2, 5, 0, 0, 0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 4; i++) issue("blink_red_add", 1, 2, 0, 0, 0, 1, 0, 0, 0, 2);
        for (int i = 0; i < 3; i++) issue("blink_op110",   3, 3, 0, 0, 0, 0, 0, 0, 0, 6);
        issue("load_mul_7_1", 7, 1, 0, 0, 0, 0, 0, 0, 0, 3);
        issue("shl_si1_a",    0, 0, 0, 1, 1, 0, 0, 0, 0, 4);
        issue("shl_si1_b",    0, 0, 0, 1, 1, 0, 0, 0, 0, 4);
        issue("rotr",         0, 0, 0, 0, 0, 0, 0, 0, 0, 5);
        issue("rotl",         0, 0, 0, 0, 1, 0, 0, 0, 0, 5);
        issue("shr_si0",      0, 0, 0, 0, 0, 0, 0, 0, 0, 4);
        drain();

        // Reset while out is non-zero, then a shift must start from zero.
        do_reset("rst_mid_shift");
        issue("shift_after_rst", 0, 0, 0, 1, 1, 0, 0, 0, 0, 4);
        issue("shift_after_rst2", 0, 0, 0, 0, 1, 0, 0, 0, 0, 4);

        for (int i = 0; i < 400; i++) begin
            a  = $urandom_range(0, 7);
            b  = $urandom_range(0, 7);
            op = $urandom_range(0, 7);
            ra = ($urandom_range(0, 3) == 0) ? 1 : 0;
            rb = ($urandom_range(0, 3) == 0) ? 1 : 0;
            pa = ($urandom_range(0, 7) == 0) ? 1 : 0;
            pb = ($urandom_range(0, 7) == 0) ? 1 : 0;
            issue("random", a, b, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                  ra, rb, pa, pb, op);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
